// File: rtl/uno_pkg.sv
// uno_pkg: shared types and constants for the uno command sequencer.
//   MAC_BW     - PE operand width (Q4.8); results are 2*MAC_BW wide
//   N_STEPS    - Horner coefficient steps for nonlinear ops
//   LEN_W      - width of the MAC-mode repeat count
//   K_W        - step counter width, max(LEN_W, clog2(N_STEPS+1))
//   op_e       - PE operation encoding
//   state_e    - sequencer FSM states
//   COEFF_TBL  - per-op Horner coefficients, Q4.8, highest order first
package uno_pkg;

  localparam int MAC_BW  = 12;
  localparam int N_STEPS = 4;
  localparam int LEN_W   = 4;
  localparam int IDX_W   = $clog2(N_STEPS);
  localparam int K_W     = (LEN_W > $clog2(N_STEPS + 1)) ? LEN_W : $clog2(N_STEPS + 1);

  // Step index of the trailing scale/offset step of a nonlinear op.
  localparam logic [K_W-1:0] K_LAST = K_W'(N_STEPS);

  typedef enum logic [1:0] {
    OP_MAC = 2'b00,
    OP_DIV = 2'b01,
    OP_EXP = 2'b10,
    OP_LOG = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_CAPT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Row order follows op_e. The MAC row is unused and kept at zero.
  // exp: 1/24, 1/6, 1/2, 1.
  localparam logic [MAC_BW-1:0] COEFF_TBL [4][N_STEPS] = '{
    '{12'd0,  12'd0,  12'd0,   12'd0},
    '{12'd32, 12'd64, 12'd128, 12'd256},
    '{12'd11, 12'd43, 12'd128, 12'd256},
    '{12'd64, 12'd85, 12'd128, 12'd256}
  };

endpackage

// File: rtl/uno_coeff_rom.sv
// uno_coeff_rom: combinational coefficient lookup for the Horner steps.
//   op    in  op_e     - operation being sequenced
//   k     in  K_W      - current step index
//   coeff out MAC_BW   - COEFF_TBL[op][k]; zero for MAC and for k >= N_STEPS
module uno_coeff_rom
  import uno_pkg::*;
(
  input  op_e               op,
  input  logic [K_W-1:0]    k,
  output logic [MAC_BW-1:0] coeff
);

  always_comb begin
    coeff = '0;
    if (op != OP_MAC && k < K_LAST) begin
      coeff = COEFF_TBL[op][k[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/uno_seq.sv
// uno_seq: command sequencer driving one uno PE.
//   clk, rst                        - clock, synchronous active-high reset
//   cmd_valid/cmd_ready             - command handshake
//   cmd_op, cmd_x, cmd_y, cmd_z     - operation and operands
//   cmd_len                         - MAC accumulation count (0 means 1)
//   pe_op, pe_x, pe_y, pe_z         - PE operands, held from the last command
//   pe_coeff                        - per-step coefficient
//   pe_first_cycle, pe_last_cycle,
//   pe_acc_en                       - PE step strobes, active only in RUN
//   pe_result                       - PE registered accumulator output
//   rsp_valid/rsp_ready, rsp_data   - result handshake
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once raised, rsp_valid and rsp_data stay stable until that
// transfer. cmd_valid is only looked at while cmd_ready is high.
module uno_seq
  import uno_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [MAC_BW-1:0]     cmd_x,
  input  logic [MAC_BW-1:0]     cmd_y,
  input  logic [2*MAC_BW-1:0]   cmd_z,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic [1:0]            pe_op,
  output logic [MAC_BW-1:0]     pe_x,
  output logic [MAC_BW-1:0]     pe_y,
  output logic [2*MAC_BW-1:0]   pe_z,
  output logic [MAC_BW-1:0]     pe_coeff,
  output logic                  pe_first_cycle,
  output logic                  pe_last_cycle,
  output logic                  pe_acc_en,
  input  logic [2*MAC_BW-1:0]   pe_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*MAC_BW-1:0]   rsp_data
);

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q;
  op_e                 op_q;
  logic [MAC_BW-1:0]   x_q, y_q;
  logic [2*MAC_BW-1:0] z_q;
  logic [LEN_W-1:0]    len_q;
  logic [K_W-1:0]      last_k;
  logic [MAC_BW-1:0]   rom_coeff;
  logic                run;

  // Index of the final step: L-1 for MAC (len 0 behaves as len 1),
  // N_STEPS for nonlinear ops (coefficient steps plus scale/offset).
  always_comb begin
    last_k = K_LAST;
    if (op_q == OP_MAC) begin
      last_k = (len_q == '0) ? '0 : K_W'(len_q) - K_W'(1);
    end
  end

  uno_coeff_rom u_rom (
    .op    (op_q),
    .k     (k_q),
    .coeff (rom_coeff)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b1;
      k_q       <= '0;
      op_q      <= OP_MAC;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      len_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == ST_IDLE);
      if (state_q == ST_IDLE && cmd_valid) begin
        op_q  <= op_e'(cmd_op);
        x_q   <= cmd_x;
        y_q   <= cmd_y;
        z_q   <= cmd_z;
        len_q <= cmd_len;
        k_q   <= '0;
      end else if (state_q == ST_RUN) begin
        k_q <= k_q + K_W'(1);
      end
      // pe_result here reflects the final step, registered by the PE.
      if (state_q == ST_CAPT) begin
        rsp_data  <= pe_result;
        rsp_valid <= 1'b1;
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_RUN;
      ST_RUN:  if (k_q == last_k) state_d = ST_CAPT;
      ST_CAPT: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // PE control outputs.
  always_comb begin
    run            = (state_q == ST_RUN);
    pe_op          = op_q;
    pe_x           = x_q;
    pe_y           = y_q;
    pe_z           = z_q;
    pe_first_cycle = run && (k_q == '0);
    pe_last_cycle  = run && (k_q == last_k);
    pe_acc_en      = run && (op_q == OP_MAC) && (k_q != '0);
    pe_coeff       = run ? rom_coeff : '0;
  end

endmodule

// File: doc/uno_seq.md
# uno_seq

Command sequencer that drives the unified `uno` PE (MAC/div/exp/log) from the initiator side. It accepts one operation per valid/ready command and generates the per-cycle PE control stream: op, operands, the coefficient sequence from a ROM, first/last-cycle strobes and acc_en. It then captures the PE accumulator output and returns it on a valid/ready response port. It sits between the array scheduler and one `uno` instance.

## Interface

- `MAC_BW`, 12: PE operand width (Q4.8); results are `2*MAC_BW`.
- `N_STEPS`, 4: Horner coefficient steps for nonlinear ops; the last_cycle step is additional.
- `LEN_W`, 4: width of the MAC-mode repeat count.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1; `cmd_ready` out 1: command handshake.
- `cmd_op` in 2: 00 MAC, 01 div, 10 exp, 11 log.
- `cmd_x`, `cmd_y` in MAC_BW: operands.
- `cmd_z` in 2*MAC_BW: MAC initial addend.
- `cmd_len` in LEN_W: MAC-mode accumulation count; ignored for other ops.
- `pe_op` out 2; `pe_x`, `pe_y` out MAC_BW; `pe_z` out 2*MAC_BW: PE operands.
- `pe_coeff` out MAC_BW: per-step coefficient.
- `pe_first_cycle`, `pe_last_cycle`, `pe_acc_en` out 1: PE step strobes.
- `pe_result` in 2*MAC_BW: PE registered MAC output (macO), 1-cycle latency.
- `rsp_valid` out 1; `rsp_ready` in 1; `rsp_data` out 2*MAC_BW: result handshake.

## Operation

- FSM states: IDLE → RUN → CAPT → RESP → IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, register op/x/y/z/len, clear step counter `k`, and go to RUN.
- **RUN, MAC op (00)**
  - Step count L = `cmd_len`; L=0 is treated as 1.
  - Step k drives `pe_acc_en` = (k≠0), `pe_first_cycle` = (k==0), `pe_last_cycle` = (k==L-1), `pe_coeff`=0.
  - After step L-1, go to CAPT.
- **RUN, nonlinear ops (01/10/11)**
  - Steps k=0..N_STEPS drive `pe_acc_en`=0.
  - `pe_first_cycle` = (k==0).
  - `pe_coeff` = ROM[op][k] for k<N_STEPS.
  - k==N_STEPS is the scale/offset step: `pe_last_cycle`=1, `pe_coeff`=0.
  - After that step, go to CAPT.
- **CAPT**
  - One cycle.
  - `rsp_data` ← `pe_result`, `rsp_valid` ← 1, go to RESP.
- **RESP**
  - Hold `rsp_data`/`rsp_valid` stable until `rsp_ready`, then clear `rsp_valid` and go to IDLE.
  - The next command is accepted no earlier than the following cycle.
- `pe_op`/`pe_x`/`pe_y`/`pe_z` are driven from the captured registers in every state and hold their value after the command completes.
- Strobes and `pe_coeff` are 0 outside RUN.
- `k` is a saturating-free counter of width max(LEN_W, clog2(N_STEPS+1)). It cannot wrap within legal ranges.
- ROM coefficients are Q4.8, in descending Horner order. exp = {11, 43, 128, 256} (1/24, 1/6, 1/2, 1). div and log tables come from the package constants.

## Timing

- Reset values:
  - state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0.
  - all pe_* outputs 0, `k`=0.
- `cmd_ready` is a registered decode of state==IDLE. It is never asserted in RUN, CAPT or RESP.
- Command accept at cycle t puts step 0 on the pe_* outputs at t+1.
- MAC latency: `rsp_valid` rises at t+L+2. Nonlinear latency: `rsp_valid` rises at t+N_STEPS+3.
- `pe_result` is sampled in CAPT, exactly one cycle after the final step.
- The PE contract is one step per cycle. The Horner dependence is satisfied by the PE's 1-cycle macO register.
- `rsp_valid` held with `rsp_ready` low: stall indefinitely, with data stable.
- `rsp_ready` high in the same cycle `rsp_valid` rises: the handshake completes that cycle.
- `cmd_valid` while busy is ignored (not captured). The command is taken only when `cmd_ready`=1.
- `rst` mid-RUN or mid-RESP: return to IDLE next cycle. The in-flight command and any pending response are dropped, and all outputs return to reset values.

## Structure

- Package `uno_pkg`:
  - `MAC_BW`
  - `op_e` enum (OP_MAC, OP_DIV, OP_EXP, OP_LOG)
  - FSM state enum
  - `N_STEPS`
  - coefficient table constant `COEFF_TBL[4][N_STEPS]`
- Sub-module `uno_coeff_rom`: combinational (op, k) → coeff read of `COEFF_TBL`. Op 00 returns 0.
- The FSM, step counter and response register live in `uno_seq`.

## Test plan

Bench uses a behavioural `uno` model (registered A*B+C).

- **MAC:** x=2, y=3, z=5, len=4.
  - Expect 4 steps: acc_en sequence 0,1,1,1; first on step 0, last on step 3.
  - `rsp_data`=29, `rsp_valid` at t+6.
- **MAC len=0:** x=7, y=1, z=0.
  - Exactly one step.
  - `rsp_data`=7.
- **exp:** op=10, x=0x080.
  - `pe_coeff` sequence 11, 43, 128, 256, then 0 with `pe_last_cycle`=1.
  - `rsp_valid` at t+7.
- **Backpressure:** `rsp_ready` low for 5 cycles.
  - `rsp_data` is stable and `cmd_ready`=0 throughout.
  - A `cmd_valid` pulse during the stall is not captured.
  - After the handshake, `cmd_ready`=1 the next cycle.
- **Reset:** assert `rst` at RUN step 2 of a div command.
  - Next cycle: IDLE, `cmd_ready`=1, all pe_* outputs 0, `rsp_valid` never asserted.
- **Back-to-back:** log then MAC commands with `cmd_valid` held high.
  - Second command is accepted only after the first response handshake.
  - Both results match the model.
